// File: rtl/mlp_ctrl_pkg.sv
// Shared types and constants for the MLP control blocks.
package mlp_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } rd_state_e;

  localparam int RD_FIFO_DEPTH = 2;
  localparam int RD_FIFO_OCCW  = $clog2(RD_FIFO_DEPTH + 1);

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry output FIFO holding read words plus their last flag.
module stream_fifo2
  import mlp_ctrl_pkg::*;
#(
  parameter int WIDTH = 129
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head_data,
  output logic [RD_FIFO_OCCW-1:0] occupancy,
  output logic                    full,
  output logic                    empty
);

  logic [WIDTH-1:0]        mem_q [RD_FIFO_DEPTH];
  logic                    rd_ptr_q;
  logic                    wr_ptr_q;
  logic [RD_FIFO_OCCW-1:0] occ_q;
  logic                    do_push;
  logic                    do_pop;

  assign full      = (occ_q == RD_FIFO_OCCW'(RD_FIFO_DEPTH));
  assign empty     = (occ_q == '0);
  assign occupancy = occ_q;
  assign head_data = mem_q[rd_ptr_q];
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);

  // Storage, pointers and fill level; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_read_streamer.sv
// Walks a contiguous memory range and streams the words out with valid/ready and a last flag.
module mem_read_streamer
  import mlp_ctrl_pkg::*;
#(
  parameter int DATAW = 128,
  parameter int DEPTH = 64,
  parameter int ADDRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADDRW-1:0] base_addr,
  input  logic [ADDRW:0]   count,
  output logic             busy,
  output logic             done,
  output logic [ADDRW-1:0] raddr,
  input  logic [DATAW-1:0] rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic             out_last
);

  rd_state_e               state_q;
  rd_state_e               state_d;
  logic [ADDRW-1:0]        addr_q;
  logic [ADDRW:0]          remain_q;
  logic                    inflight_q;
  logic                    inflight_last_q;
  logic                    cmd_done_q;
  logic                    zero_done_q;

  logic                    accept;
  logic                    issue;
  logic                    issue_ok;
  logic                    pop;
  logic                    head_last;
  logic [RD_FIFO_OCCW-1:0] fifo_occ;
  logic [RD_FIFO_OCCW-1:0] credit_sum;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [DATAW:0]          head_entry;

  // A start is only taken while fully idle, including the cycle that reports done.
  assign accept     = start && (state_q == IDLE) && !cmd_done_q;
  assign busy       = (state_q != IDLE) || cmd_done_q;
  assign done       = cmd_done_q || zero_done_q;
  assign raddr      = addr_q;
  assign out_valid  = !fifo_empty;
  assign out_data   = head_entry[DATAW-1:0];
  assign head_last  = head_entry[DATAW];
  assign out_last   = out_valid && head_last;
  assign pop        = out_valid && out_ready;
  assign credit_sum = fifo_occ + RD_FIFO_OCCW'(inflight_q);

  // Next state plus issue decision; a read may only go out if its word is guaranteed a FIFO slot.
  always_comb begin
    state_d  = state_q;
    issue_ok = 1'b0;
    issue    = 1'b0;
    if (fifo_full) begin
      issue_ok = pop;
    end else begin
      issue_ok = (credit_sum < 2'd2) || ((credit_sum == 2'd2) && pop);
    end
    case (state_q)
      IDLE: begin
        if (accept && (count != '0)) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        issue = issue_ok;
        if (issue_ok && (remain_q == (ADDRW+1)'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Address/remaining counters, in-flight tracking and done pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q          <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      cmd_done_q      <= 1'b0;
      zero_done_q     <= 1'b0;
    end else begin
      if (accept && (count != '0)) begin
        addr_q   <= base_addr;
        remain_q <= count;
      end else if (issue) begin
        addr_q   <= (addr_q == ADDRW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
        remain_q <= remain_q - 1'b1;
      end
      inflight_q      <= issue;
      inflight_last_q <= issue && (remain_q == (ADDRW+1)'(1));
      cmd_done_q      <= (state_q == DRAIN) && pop && head_last;
      zero_done_q     <= accept && (count == '0);
    end
  end

  stream_fifo2 #(
    .WIDTH(DATAW + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_q),
    .push_data({inflight_last_q, rdata}),
    .pop      (pop),
    .head_data(head_entry),
    .occupancy(fifo_occ),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule
